// File: rtl/ecc_scrub_controller_pkg.sv
// Shared constants, FSM state encoding and a saturating-count helper
// for the ECC scrub controller.
package ecc_scrub_controller_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam logic [7:0] COUNT_MAX = 8'd255;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HOST_RD   = 3'd1,
        SCRUB_RD  = 3'd2,
        SCRUB_CHK = 3'd3,
        SCRUB_WB  = 3'd4
    } state_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        if (value == COUNT_MAX) begin
            sat_inc = COUNT_MAX;
        end else begin
            sat_inc = value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/ecc_scrub_controller_timer.sv
// Scrub interval timer: launches at most one pending scrub step per
// interval while scrubbing is enabled.
module ecc_scrub_timer #(
    parameter int SCRUB_INTERVAL = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic scrub_enable,
    input  logic launch,
    output logic scrub_pending
);

    localparam logic [15:0] LAST_COUNT = 16'(SCRUB_INTERVAL - 1);

    logic [15:0] count_r;
    logic        pending_r;
    logic        wrap_s;

    assign wrap_s        = scrub_enable && (count_r == LAST_COUNT);
    assign scrub_pending = pending_r;

    // Interval counter; parked at zero while scrubbing is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 16'd0;
        end else if (!scrub_enable || wrap_s) begin
            count_r <= 16'd0;
        end else begin
            count_r <= count_r + 16'd1;
        end
    end

    // Pending flag; a launch wins over a coincident wrap, so that wrap is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= 1'b0;
        end else if (!scrub_enable || launch) begin
            pending_r <= 1'b0;
        end else if (wrap_s) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

endmodule

// File: rtl/ecc_scrub_controller.sv
// Host access arbiter plus background scrubber for a small ECC-protected
// memory; corrected words found by scrubbing are written back.
module ecc_scrub_controller
    import ecc_scrub_controller_pkg::*;
#(
    parameter int SCRUB_INTERVAL = 256,
    parameter int DEPTH          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_err_corrected,
    input  logic              scrub_enable,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err_corrected,
    output logic              scrub_busy,
    output logic [7:0]        corrected_count,
    output logic [ADDR_W-1:0] last_err_addr
);

    state_e              state_r, state_s;
    logic [ADDR_W-1:0]   scrub_ptr_r, next_ptr_s;
    logic [DATA_W-1:0]   scrub_data_r, rd_data_r;
    logic                scrub_flag_r, rd_corr_r, rd_ack_r, busy_r;
    logic [7:0]          count_r;
    logic [ADDR_W-1:0]   last_err_r;
    logic                launch_s, pending_s, host_go_s, wr_ack_s;
    logic                mem_wr_en_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_s;

    ecc_scrub_timer #(.SCRUB_INTERVAL(SCRUB_INTERVAL)) u_timer (
        .clk           (clk),
        .rst           (rst),
        .scrub_enable  (scrub_enable),
        .launch        (launch_s),
        .scrub_pending (pending_s)
    );

    // The request is still high during a read's ack cycle; it must not start a second access.
    assign host_go_s  = host_req && !rd_ack_r;
    assign next_ptr_s = (scrub_ptr_r == ADDR_W'(DEPTH - 1)) ? {ADDR_W{1'b0}} : scrub_ptr_r + 4'd1;

    assign host_ack           = wr_ack_s | rd_ack_r;
    assign host_rdata         = rd_data_r;
    assign host_err_corrected = rd_corr_r;
    assign mem_wr_en          = mem_wr_en_s;
    assign mem_addr           = mem_addr_s;
    assign mem_wdata          = mem_wdata_s;
    assign scrub_busy         = busy_r;
    assign corrected_count    = count_r;
    assign last_err_addr      = last_err_r;

    // Next-state and memory-port decode; everything is held quiet during reset.
    always_comb begin
        state_s     = state_r;
        launch_s    = 1'b0;
        wr_ack_s    = 1'b0;
        mem_wr_en_s = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        if (rst) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (host_go_s && host_we) begin
                        mem_wr_en_s = 1'b1;
                        mem_addr_s  = host_addr;
                        mem_wdata_s = host_wdata;
                        wr_ack_s    = 1'b1;
                    end else if (host_go_s) begin
                        mem_addr_s = host_addr;
                        state_s    = HOST_RD;
                    end else if (pending_s) begin
                        mem_addr_s = scrub_ptr_r;
                        launch_s   = 1'b1;
                        state_s    = SCRUB_RD;
                    end else begin
                        state_s = IDLE;
                    end
                end
                HOST_RD: begin
                    mem_addr_s = host_addr;
                    state_s    = IDLE;
                end
                SCRUB_RD: begin
                    mem_addr_s = scrub_ptr_r;
                    state_s    = SCRUB_CHK;
                end
                SCRUB_CHK: begin
                    mem_addr_s = scrub_ptr_r;
                    state_s    = scrub_flag_r ? SCRUB_WB : IDLE;
                end
                SCRUB_WB: begin
                    mem_wr_en_s = 1'b1;
                    mem_addr_s  = scrub_ptr_r;
                    mem_wdata_s = scrub_data_r;
                    state_s     = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State register, read/scrub capture registers and scrub statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            rd_ack_r     <= 1'b0;
            rd_data_r    <= {DATA_W{1'b0}};
            rd_corr_r    <= 1'b0;
            scrub_data_r <= {DATA_W{1'b0}};
            scrub_flag_r <= 1'b0;
            scrub_ptr_r  <= {ADDR_W{1'b0}};
            count_r      <= 8'd0;
            last_err_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r  <= state_s;
            busy_r   <= (state_s == SCRUB_RD) || (state_s == SCRUB_CHK) || (state_s == SCRUB_WB);
            rd_ack_r <= (state_r == HOST_RD);
            if (state_r == HOST_RD) begin
                rd_data_r <= mem_rdata;
                rd_corr_r <= mem_err_corrected;
            end
            if (state_r == SCRUB_RD) begin
                scrub_data_r <= mem_rdata;
                scrub_flag_r <= mem_err_corrected;
            end
            if (((state_r == SCRUB_CHK) && !scrub_flag_r) || (state_r == SCRUB_WB)) begin
                scrub_ptr_r <= next_ptr_s;
            end
            if (state_r == SCRUB_WB) begin
                count_r    <= sat_inc(count_r);
                last_err_r <= scrub_ptr_r;
            end
        end
    end

endmodule

// File: tb/tb_ecc_scrub_controller.sv
// Scoreboard bench: stimulus queues expected host responses and scrub
// write-backs; a negedge monitor pops and compares them as the DUT presents them.
module tb_ecc_scrub_controller;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = 4'd0;
    logic [7:0] host_wdata = 8'd0;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       host_err_corrected;
    logic       scrub_enable = 1'b0;
    logic       mem_wr_en;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'd0;
    logic       mem_err_corrected = 1'b0;
    logic       scrub_busy;
    logic [7:0] corrected_count;
    logic [3:0] last_err_addr;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
        logic       corr;
    } host_exp_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wb_exp_t;

    host_exp_t host_q[$];
    wb_exp_t   wb_q[$];

    // memory seen by the DUT (decoded data + "was corrected" flag)
    logic [7:0] bmem   [DEPTH] = '{default: 8'h00};
    logic       bfault [DEPTH] = '{default: 1'b0};
    // reference view kept by the stimulus
    logic [7:0] ref_mem   [DEPTH] = '{default: 8'h00};
    logic       ref_fault [DEPTH] = '{default: 1'b0};

    int model_ptr   = 0;
    int scrub_steps = 0;
    logic prev_busy = 1'b0;
    int model_count = 0;
    int model_last  = 0;

    logic       inj_valid = 1'b0;
    logic [3:0] inj_addr = 4'd0;
    logic [7:0] inj_data = 8'd0;

    ecc_scrub_controller #(.SCRUB_INTERVAL(8), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .host_req           (host_req),
        .host_we            (host_we),
        .host_addr          (host_addr),
        .host_wdata         (host_wdata),
        .host_ack           (host_ack),
        .host_rdata         (host_rdata),
        .host_err_corrected (host_err_corrected),
        .scrub_enable       (scrub_enable),
        .mem_wr_en          (mem_wr_en),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .mem_err_corrected  (mem_err_corrected),
        .scrub_busy         (scrub_busy),
        .corrected_count    (corrected_count),
        .last_err_addr      (last_err_addr)
    );

    always #5 clk = ~clk;

    // ECC memory + decoder model: one-cycle read latency, writes clear the fault.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            bmem[mem_addr]   <= mem_wdata;
            bfault[mem_addr] <= 1'b0;
        end
        if (inj_valid) begin
            bmem[inj_addr]   <= inj_data;
            bfault[inj_addr] <= 1'b1;
        end
        mem_rdata         <= bmem[mem_addr];
        mem_err_corrected <= bfault[mem_addr];
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endfunction

    // Monitor: scrub visiting order, scrub write-backs and host responses.
    initial begin
        host_exp_t he;
        wb_exp_t   we_;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_ptr = 0;
                prev_busy = 1'b0;
            end else begin
                if (scrub_busy && !prev_busy) begin
                    chk("scrub_addr", 32'(mem_addr), 32'(model_ptr));
                    model_ptr = (model_ptr + 1) % DEPTH;
                    scrub_steps++;
                end
                prev_busy = scrub_busy;
                if (mem_wr_en && scrub_busy) begin
                    if (wb_q.size() == 0) begin
                        fail_now("unexpected_scrub_write", $sformatf("addr 0x%0h data 0x%0h, expected none", mem_addr, mem_wdata));
                    end else begin
                        we_ = wb_q.pop_front();
                        chk("wb_addr", 32'(mem_addr), 32'(we_.addr));
                        chk("wb_data", 32'(mem_wdata), 32'(we_.data));
                    end
                end
                if (mem_wr_en && !scrub_busy && !host_ack) begin
                    fail_now("stray_write", $sformatf("addr 0x%0h with no ack and not scrubbing", mem_addr));
                end
                if (host_ack) begin
                    chk("ack_while_scrub_busy", 32'(scrub_busy), 32'd0);
                    if (host_q.size() == 0) begin
                        fail_now("unexpected_ack", "ack with no outstanding request");
                    end else begin
                        he = host_q.pop_front();
                        if (he.we) begin
                            chk("host_wr_en", 32'(mem_wr_en), 32'd1);
                            chk("host_wr_addr", 32'(mem_addr), 32'(he.addr));
                            chk("host_wr_data", 32'(mem_wdata), 32'(he.data));
                        end else begin
                            chk("host_rdata", 32'(host_rdata), 32'(he.data));
                            chk("host_err_corrected", 32'(host_err_corrected), 32'(he.corr));
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic host_op(input logic we, input logic [3:0] a, input logic [7:0] d, output int lat);
        host_exp_t e;
        e.we   = we;
        e.addr = a;
        e.data = we ? d : ref_mem[a];
        e.corr = we ? 1'b0 : ref_fault[a];
        host_q.push_back(e);
        if (we) begin
            ref_mem[a]   = d;
            ref_fault[a] = 1'b0;
        end
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        for (lat = 0; lat < 200; lat++) begin
            @(negedge clk);
            if (host_ack) break;
            @(posedge clk);
        end
        if (lat >= 200) fail_now("host_ack_timeout", $sformatf("no ack for addr 0x%0h", a));
        @(posedge clk);
        #2;
        host_req = 1'b0;
    endtask

    task automatic inject(input logic [3:0] a, input logic [7:0] d);
        inj_addr = a; inj_data = d; inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        ref_mem[a]   = d;
        ref_fault[a] = 1'b1;
    endtask

    task automatic stop_scrub();
        scrub_enable = 1'b0;
        repeat (8) tick();
        chk("scrub_stopped", 32'(scrub_busy), 32'd0);
    endtask

    task automatic drain_wb(input int bound);
        int n = 0;
        while (wb_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (wb_q.size() != 0) begin
            errors++;
            $display("FAIL wb_drain_timeout: %0d write-backs still missing, required 0", wb_q.size());
            wb_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_host_ack"}, 32'(host_ack), 32'd0);
        chk({tag, "_host_rdata"}, 32'(host_rdata), 32'd0);
        chk({tag, "_host_err"}, 32'(host_err_corrected), 32'd0);
        chk({tag, "_mem_wr_en"}, 32'(mem_wr_en), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_scrub_busy"}, 32'(scrub_busy), 32'd0);
        chk({tag, "_count"}, 32'(corrected_count), 32'd0);
        chk({tag, "_last_err"}, 32'(last_err_addr), 32'd0);
    endtask

    // Safety net so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat, n, total, start;
        logic [3:0] a;
        logic [7:0] d;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // basic write then read with fixed latency
        host_op(1'b1, 4'd3, 8'hA5, lat);
        chk("write_ack_latency", 32'(lat), 32'd0);
        host_op(1'b0, 4'd3, 8'h00, lat);
        chk("read_ack_latency", 32'(lat), 32'd2);

        for (int i = 0; i < DEPTH; i++) begin
            host_op(1'b1, 4'(i), 8'($urandom_range(0, 255)), lat);
        end

        // 17 fault-free scrub steps: monitor checks order, no writes allowed
        start = scrub_steps;
        scrub_enable = 1'b1;
        n = 0;
        while (scrub_steps < start + 17 && n < 600) begin
            tick();
            n++;
        end
        chk("seventeen_steps_reached", 32'(scrub_steps >= start + 17), 32'd1);
        stop_scrub();
        chk("count_after_clean_pass", 32'(corrected_count), 32'd0);

        // single corrected word at address 5
        inject(4'd5, 8'h3C);
        wb_q.push_back('{addr: 4'd5, data: 8'h3C});
        model_count = 1;
        model_last  = 5;
        scrub_enable = 1'b1;
        drain_wb(400);
        stop_scrub();
        ref_fault[5] = 1'b0;
        chk("count_after_one", 32'(corrected_count), 32'(model_count));
        chk("last_err_after_one", 32'(last_err_addr), 32'(model_last));

        // random host traffic with scrubbing running
        scrub_enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom_range(0, DEPTH - 1));
            d = 8'($urandom_range(0, 255));
            host_op(1'($urandom_range(0, 1)), a, d, lat);
            repeat ($urandom_range(0, 4)) tick();
        end

        // host read raised during SCRUB_RD is held off until the step ends
        n = 0;
        while (scrub_busy && n < 20) begin tick(); n++; end
        n = 0;
        while (!scrub_busy && n < 50) begin tick(); n++; end
        chk("scrub_started", 32'(scrub_busy), 32'd1);
        host_op(1'b0, 4'($urandom_range(0, DEPTH - 1)), 8'h00, lat);
        chk("held_off_latency", 32'(lat), 32'd4);
        stop_scrub();

        // random fault batches until the counter has saturated and kept going
        total = 1;
        while (total < 262) begin
            start = model_ptr;
            for (int k = 0; k < DEPTH; k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    a = 4'((start + k) % DEPTH);
                    d = 8'($urandom_range(0, 255));
                    inject(a, d);
                    wb_q.push_back('{addr: a, data: d});
                    model_count = (model_count >= 255) ? 255 : model_count + 1;
                    model_last  = int'(a);
                    total++;
                end
            end
            scrub_enable = 1'b1;
            drain_wb(400);
            stop_scrub();
            for (int k = 0; k < DEPTH; k++) ref_fault[k] = 1'b0;
            chk("batch_count", 32'(corrected_count), 32'(model_count));
            chk("batch_last_err", 32'(last_err_addr), 32'(model_last));
        end
        chk("count_saturated", 32'(corrected_count), 32'd255);

        // reset while SCRUB_CHK holds a corrected word: no write-back
        a = 4'(model_ptr);
        d = 8'($urandom_range(0, 255));
        inject(a, d);
        scrub_enable = 1'b1;
        n = 0;
        while (!scrub_busy && n < 50) begin tick(); n++; end
        chk("fault_step_started", 32'(scrub_busy), 32'd1);
        tick();
        rst = 1'b1;
        scrub_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_wb_in_reset", 32'(mem_wr_en), 32'd0);
        end
        check_reset_outputs("mid_step_reset");
        tick();
        rst = 1'b0;
        model_count = 0;
        model_last  = 0;
        tick();
        host_op(1'b0, a, 8'h00, lat);
        tick();

        chk("scoreboard_empty", 32'(host_q.size() + wb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
